// File: rtl/pipelined_param_adder.sv
// pipelined_param_adder
//   WIDTH-bit add (A+B+cin) or subtract (A-B) split into SEG-bit segments.
//   Each pipeline stage resolves one segment and registers the carry for the
//   next one. Results appear STAGES = WIDTH/SEG cycles after acceptance.
//   Throughput is one beat per cycle. The whole pipeline freezes while the
//   output holds a result that downstream has not yet taken.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operand beat valid
//   in_ready   beat accepted this cycle (combinational global advance)
//   a, b       unsigned operands
//   cin        carry-in, used only for adds
//   sub        0: a+b+cin, 1: a-b (a + ~b + 1)
//   out_valid  result valid
//   out_ready  downstream accepts result
//   sum        result bits (modulo 2^WIDTH)
//   cout       carry out of MSB (for subtract, 1 means a >= b)
//   ovf        signed overflow, present only with PIPE_ADDER_OVF_EN defined
//
// Optional feature macro: PIPE_ADDER_OVF_EN
module pipelined_param_adder #(
  parameter int WIDTH = 16,
  parameter int SEG   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef PIPE_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int STAGES = WIDTH / SEG;

  if ((SEG < 1) || (WIDTH < SEG) || ((WIDTH % SEG) != 0)) begin : g_bad_params
    $error("pipelined_param_adder: WIDTH must be a positive integer multiple of SEG");
  end

  // Per-stage state. Operands travel full width so every stage can pick its
  // own segment; the result word accumulates the resolved low segments.
  logic [STAGES-1:0]            vld_q, vld_d;
  logic [STAGES-1:0]            c_q, c_d;
  logic [STAGES-1:0][WIDTH-1:0] a_q, a_d;
  logic [STAGES-1:0][WIDTH-1:0] b_q, b_d;
  logic [STAGES-1:0][WIDTH-1:0] r_q, r_d;
`ifdef PIPE_ADDER_OVF_EN
  logic                         ovf_q, ovf_d;
`endif

  logic             adv;
  logic             accept;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic [WIDTH-1:0] src_r;
  logic             src_c;
  logic             src_v;
  logic [SEG:0]     seg_sum;

  // Only a result parked at the output and refused downstream stops the pipe.
  assign adv      = !(vld_q[STAGES-1] && !out_ready);
  assign in_ready = adv;
  assign accept   = in_valid && adv;

  always_comb begin
    vld_d = vld_q;
    c_d   = c_q;
    a_d   = a_q;
    b_d   = b_q;
    r_d   = r_q;
`ifdef PIPE_ADDER_OVF_EN
    ovf_d = ovf_q;
`endif
    // Stage 0 source is the incoming beat; subtract folds into ~b with carry 1.
    src_a   = a;
    src_b   = sub ? ~b : b;
    src_r   = '0;
    src_c   = sub | cin;
    src_v   = accept;
    seg_sum = '0;
    for (int k = 0; k < STAGES; k++) begin
      seg_sum = {1'b0, src_a[k*SEG +: SEG]} + {1'b0, src_b[k*SEG +: SEG]}
              + {{SEG{1'b0}}, src_c};
      vld_d[k] = src_v;
      // Data registers load only with a real beat, so a bubble leaves the
      // last result visible on sum/cout.
      if (src_v) begin
        a_d[k]              = src_a;
        b_d[k]              = src_b;
        r_d[k]              = src_r;
        r_d[k][k*SEG +: SEG] = seg_sum[SEG-1:0];
        c_d[k]              = seg_sum[SEG];
`ifdef PIPE_ADDER_OVF_EN
        // Carry into the MSB is recovered from the MSB sum bit.
        if (k == STAGES - 1) begin
          ovf_d = src_a[WIDTH-1] ^ src_b[WIDTH-1] ^ seg_sum[SEG-1] ^ seg_sum[SEG];
        end
`endif
      end
      src_a = a_q[k];
      src_b = b_q[k];
      src_r = r_q[k];
      src_c = c_q[k];
      src_v = vld_q[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      c_q   <= '0;
      a_q   <= '0;
      b_q   <= '0;
      r_q   <= '0;
`ifdef PIPE_ADDER_OVF_EN
      ovf_q <= 1'b0;
`endif
    end else if (adv) begin
      vld_q <= vld_d;
      c_q   <= c_d;
      a_q   <= a_d;
      b_q   <= b_d;
      r_q   <= r_d;
`ifdef PIPE_ADDER_OVF_EN
      ovf_q <= ovf_d;
`endif
    end
  end

  assign out_valid = vld_q[STAGES-1];
  assign sum       = r_q[STAGES-1];
  assign cout      = c_q[STAGES-1];
`ifdef PIPE_ADDER_OVF_EN
  assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_pipelined_param_adder.sv
module tb_pipelined_param_adder;
  localparam int W      = 16;
  localparam int SEG    = 4;
  localparam int STAGES = W / SEG;

  logic         clk       = 1'b0;
  logic         rst_n     = 1'b0;
  logic         in_valid  = 1'b0;
  logic         in_ready;
  logic [W-1:0] a         = '0;
  logic [W-1:0] b         = '0;
  logic         cin       = 1'b0;
  logic         sub       = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] sum;
  logic         cout;
`ifdef PIPE_ADDER_OVF_EN
  logic         ovf;
`endif

  always #5 clk = ~clk;

  pipelined_param_adder #(.WIDTH(W), .SEG(SEG)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
`ifdef PIPE_ADDER_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    logic         o;
    int           stamp;
  } exp_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic [W-1:0] s;
    logic         c;
    logic         o;
  } vec_t;

  exp_t         exp_q[$];
  logic [W-1:0] rx[$];
  vec_t         vt[10];
  int           n_checks  = 0;
  int           n_fail    = 0;
  bit           mon_en    = 1'b0;
  bit           done      = 1'b0;
  int           adv_cnt   = 0;
  logic [W-1:0] last_sum  = '0;
  logic         last_cout = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Plain integer arithmetic reference.
  function automatic exp_t ref_model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                     input logic ci, input logic sb, input int stamp);
    exp_t e;
    int   full;
    int   sa;
    int   sbv;
    int   r;
    sa  = int'($signed(av));
    sbv = int'($signed(bv));
    if (sb) begin
      e.s  = av - bv;
      e.c  = (av >= bv);
      r    = sa - sbv;
    end else begin
      full = int'(av) + int'(bv) + int'(ci);
      e.s  = full[W-1:0];
      e.c  = full[W];
      r    = sa + sbv + int'(ci);
    end
    e.o     = (r > 32767) || (r < -32768);
    e.stamp = stamp;
    return e;
  endfunction

  // Scoreboard: a beat accepted on an advancing edge must reach the output
  // after STAGES advancing edges in total; stalls freeze everything.
  always @(negedge clk) begin : mon
    bit   ev;
    bit   adv_e;
    exp_t e;
    if (mon_en) begin
      ev    = (exp_q.size() > 0) && (adv_cnt >= exp_q[0].stamp + STAGES - 1);
      adv_e = !(ev && !out_ready);
      chk("out_valid", 32'(out_valid), 32'(ev));
      chk("in_ready", 32'(in_ready), 32'(adv_e));
      if (ev) begin
        chk("sum", 32'(sum), 32'(exp_q[0].s));
        chk("cout", 32'(cout), 32'(exp_q[0].c));
`ifdef PIPE_ADDER_OVF_EN
        chk("ovf", 32'(ovf), 32'(exp_q[0].o));
`endif
        if (out_ready) begin
          rx.push_back(sum);
          void'(exp_q.pop_front());
        end
      end else begin
        chk("sum_hold", 32'(sum), 32'(last_sum));
        chk("cout_hold", 32'(cout), 32'(last_cout));
      end
      if (out_valid) begin
        last_sum  = sum;
        last_cout = cout;
      end
      if (adv_e && in_valid) begin
        e = ref_model(a, b, cin, sub, adv_cnt + 1);
        exp_q.push_back(e);
      end
      if (adv_e) adv_cnt++;
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv,
                      input logic ci, input logic sb);
    int t;
    bit acc;
    a = av; b = bv; cin = ci; sub = sb; in_valid = 1'b1;
    t = 0; acc = 1'b0;
    while (!acc && t < 200) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      t++;
    end
    if (!acc) chk("accept_timeout", 32'(acc), 32'(1));
    in_valid = 1'b0;
    // Junk between beats must not matter.
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || out_valid) && t < 100) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("drain", 32'(exp_q.size()), 32'(0));
  endtask

  task automatic do_reset();
    mon_en   = 1'b0;
    in_valid = 1'b0;
    rst_n    = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'(1));
    chk("rst_out_valid", 32'(out_valid), 32'(0));
    chk("rst_sum", 32'(sum), 32'(0));
    rst_n = 1'b1;
    exp_q.delete();
    last_sum  = '0;
    last_cout = 1'b0;
    @(posedge clk);
    #1;
    mon_en = 1'b1;
  endtask

  task automatic run_vec(input vec_t v);
    send(v.a, v.b, v.cin, v.sub);
    repeat (STAGES - 2) @(posedge clk);
    @(negedge clk);
    chk("vec_early", 32'(out_valid), 32'(0));
    @(posedge clk);
    @(negedge clk);
    chk("vec_valid", 32'(out_valid), 32'(1));
    chk("vec_sum", 32'(sum), 32'(v.s));
    chk("vec_cout", 32'(cout), 32'(v.c));
`ifdef PIPE_ADDER_OVF_EN
    chk("vec_ovf", 32'(ovf), 32'(v.o));
`endif
    @(posedge clk);
    @(negedge clk);
    chk("vec_after", 32'(out_valid), 32'(0));
    @(posedge clk);
    #1;
  endtask

  initial begin
    vt[0] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
    vt[1] = '{16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
    vt[2] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vt[3] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    vt[4] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    vt[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};
    vt[6] = '{16'h1234, 16'h1234, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
    vt[7] = '{16'h0000, 16'h0001, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0};
    vt[8] = '{16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0};
    vt[9] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};

    do_reset();

    // Directed vectors, one beat at a time with exact latency.
    for (int i = 0; i < 10; i++) run_vec(vt[i]);

    // Back-to-back stream with free-running output.
    rx.delete();
    for (int k = 0; k < 20; k++) send(W'(k), W'(2 * k), 1'b0, 1'b0);
    drain();
    chk("stream_count", 32'(rx.size()), 32'(20));
    for (int i = 0; i < rx.size(); i++) chk("stream_sum", 32'(rx[i]), 32'(3 * i));

    // Same stream with out_ready pattern 1,0,0,1.
    rx.delete();
    done = 1'b0;
    fork
      begin
        for (int k = 0; k < 20; k++) send(W'(k), W'(2 * k), 1'b0, 1'b0);
        done = 1'b1;
      end
      begin
        int p;
        p = 0;
        while (!done) begin
          out_ready = ((p % 4) == 0) || ((p % 4) == 3);
          p++;
          @(posedge clk);
          #1;
        end
      end
    join
    out_ready = 1'b1;
    drain();
    chk("stall_count", 32'(rx.size()), 32'(20));
    for (int i = 0; i < rx.size(); i++) chk("stall_sum", 32'(rx[i]), 32'(3 * i));

    // Reset while beats are in flight.
    send(16'h1111, 16'h2222, 1'b0, 1'b0);
    send(16'h0101, 16'h0202, 1'b1, 1'b0);
    send(16'h4000, 16'h0001, 1'b0, 1'b1);
    @(posedge clk);
    #3;
    chk("pre_rst_valid", 32'(out_valid), 32'(1));
    mon_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    chk("async_valid", 32'(out_valid), 32'(0));
    chk("async_sum", 32'(sum), 32'(0));
    chk("async_cout", 32'(cout), 32'(0));
    chk("async_in_ready", 32'(in_ready), 32'(1));
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    last_sum  = '0;
    last_cout = 1'b0;
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("post_rst_valid", 32'(out_valid), 32'(0));
    end
    @(posedge clk);
    #1;
    run_vec(vt[0]);

    // Random traffic with random backpressure.
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      a         = W'($urandom);
      b         = W'($urandom);
      cin       = 1'($urandom);
      sub       = 1'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipelined_param_adder.md
Name: pipelined_param_adder

Overview:
- Parametrised, pipelined successor to the team's 4-bit parallel adder.
- Adds two WIDTH-bit operands with carry-in, or subtracts them; the operation is cut into SEG-bit segments, one segment resolved per pipeline stage, with the carry registered between stages.
- Valid/ready handshake on input and output; sits in datapaths that need wide adds at high clock rate with one result per cycle.

Parameters:
WIDTH, 16, operand and result width in bits; must be an integer multiple of SEG (elaboration error otherwise).
SEG, 4, bits resolved per stage; STAGES = WIDTH/SEG (derived, not overridable), STAGES >= 1.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  operand beat valid.
in_ready  output  1  block accepts beat this cycle.
a  input  WIDTH  operand A, unsigned.
b  input  WIDTH  operand B, unsigned.
cin  input  1  carry-in; used only when sub=0.
sub  input  1  0: A+B+cin; 1: A-B (A + ~B + 1, cin ignored).
out_valid  output  1  result valid.
out_ready  input  1  downstream accepts result.
sum  output  WIDTH  result bits.
cout  output  1  carry-out of MSB (sub=1: 1 means no borrow, A>=B).

Behaviour:
- Reset (async assert, sync release): all stage valid bits, out_valid, sum, cout, and all carry/skew registers go to 0. in_ready reads 1 during and after reset.
- Global advance: adv = !(out_valid && !out_ready). in_ready = adv (combinational). All pipeline registers load only when adv=1; otherwise everything holds, sum/cout stable.
- Accept: beat taken when in_valid && in_ready. Stage 0 registers segment 0 of a and b_eff (b or ~b), carry-in (cin or 1), and skewed copies of the upper segments of a/b_eff.
- Stage k (1..STAGES-1) adds segment k using stage k-1's registered carry; the lower result segments travel with the beat.
- Latency: result on sum/cout with out_valid=1 exactly STAGES cycles after acceptance, given no stall. Throughput: 1 beat/cycle.
- Bubbles: a cycle with adv=1 and no accept injects valid=0, which propagates. out_valid is 0 whenever the final stage holds a bubble; sum/cout then hold their last values.
- Stall: out_valid=1, out_ready=0 freezes the whole pipeline and deasserts in_ready. No beat is lost or duplicated.
- Width: arithmetic is modulo 2^WIDTH; cout is bit WIDTH of the full (WIDTH+1)-bit sum. STAGES=1 degenerates to a single registered adder, latency 1.
- sub and cin are sampled with their beat only; changes at other times have no effect.
- Reset mid-operation discards all in-flight beats. No out_valid pulse follows release until a new beat has traversed STAGES cycles.

Optional Feature:
- Macro PIPE_ADDER_OVF_EN.
- Defined: extra output port ovf (1 bit), signed two's-complement overflow of the same operation (carry into MSB XOR carry out of MSB). It is aligned with sum, reset to 0, and held during stalls.
- Undefined: port ovf absent. Logic and timing otherwise identical.

Test Plan (WIDTH=16, SEG=4, STAGES=4):
1. Reset, then a=0x1234, b=0x4321, cin=0, sub=0, out_ready=1 -> 4 cycles later out_valid=1, sum=0x5555, cout=0; the next cycle out_valid=0.
2. a=0xFFFF, b=0x0000, cin=1 -> sum=0x0000, cout=1 (carry ripples across all 4 stages). a=0x0005, b=0x0007, sub=1 -> sum=0xFFFE, cout=0.
3. Back-to-back stream a=k, b=2k for k=0..19, out_ready=1 -> 20 consecutive out_valid cycles, sum=3k in order, in_ready constantly 1.
4. Same stream with out_ready toggled 1,0,0,1 repeating -> in_ready=0 exactly when out_valid && !out_ready; sum stable while stalled; all 20 results arrive in order with no loss or duplication.
5. Accept 3 beats, assert rst_n=0 for 1 cycle mid-flight -> out_valid, sum, cout are 0 immediately (async). No out_valid after release until a fresh beat completes its 4 cycles.
6. With PIPE_ADDER_OVF_EN: a=0x7FFF, b=0x0001, sub=0 -> sum=0x8000, ovf=1, cout=0. a=0x8000, b=0x0001, sub=1 -> sum=0x7FFF, ovf=1, cout=1.
